// File: rtl/frogger_pkg.sv
// Shared types, HID keycodes and the key-to-direction map for the frog move path.
package frogger_pkg;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef struct packed {
      logic hit;
      dir_t dir;
   } key_map_t;

   localparam logic [7:0] KC_ROLLOVER = 8'h01;
   localparam logic [7:0] KC_A        = 8'h04;
   localparam logic [7:0] KC_D        = 8'h07;
   localparam logic [7:0] KC_S        = 8'h16;
   localparam logic [7:0] KC_W        = 8'h1A;
   localparam logic [7:0] KC_SPACE    = 8'h2C;
   localparam logic [7:0] KC_RIGHT    = 8'h4F;
   localparam logic [7:0] KC_LEFT     = 8'h50;
   localparam logic [7:0] KC_DOWN     = 8'h51;
   localparam logic [7:0] KC_UP       = 8'h52;

   // WASD and the arrow keys both steer the frog; anything else is not a move.
   function automatic key_map_t map_key(input logic [7:0] code);
      key_map_t m;
      m.hit = 1'b1;
      m.dir = DIR_UP;
      case (code)
         KC_W, KC_UP:    m.dir = DIR_UP;
         KC_S, KC_DOWN:  m.dir = DIR_DOWN;
         KC_A, KC_LEFT:  m.dir = DIR_LEFT;
         KC_D, KC_RIGHT: m.dir = DIR_RIGHT;
         default:        m.hit = 1'b0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/move_fifo.sv
// Small power-of-two FIFO of frog directions with occupancy count and a sticky
// overflow flag. A push into a full FIFO is accepted only if a pop frees a slot
// in the same cycle; otherwise it is dropped and flagged.
module move_fifo
   import frogger_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  dir_t                   push_dir,
   input  logic                   pop,
   output logic                   valid,
   output dir_t                   head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   dir_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          do_pop;
   logic          do_push;

   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign do_push = push && (!full || do_pop);
   assign valid   = (count != '0);
   assign head    = mem[rd_ptr];

   // Storage, wrapping pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= DIR_UP;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_dir;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push && !do_push) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/frog_move_decoder.sv
// Samples the NIOS keycode export once per frame (falling VGA_VS), turns new
// key presses into frog moves queued in move_fifo, and pulses pause_toggle on a
// new space press. Optional held-key autorepeat: FROGGER_AUTOREPEAT_EN.
module frog_move_decoder
   import frogger_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int REPEAT_DELAY = 20,
   parameter int REPEAT_RATE  = 6
) (
   input  logic                   Clk,
   input  logic                   Reset,
   input  logic [15:0]            keycode,
   input  logic                   frame_vs,
   output logic                   move_valid,
   output logic [1:0]             move_dir,
   input  logic                   move_ready,
   output logic                   pause_toggle,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic                   overflow
);

   logic        vs_s1, vs_s2, vs_d;
   logic        tick;
   logic        rollover;
   logic        decode_en;
   logic [15:0] cur_sample;
   logic [15:0] prev_sample;
   key_map_t    m0, m1;
   logic        new0, new1;
   logic        press_hit;
   dir_t        press_dir;
   logic        rep_fire;
   dir_t        rep_dir_out;
   logic        push;
   dir_t        push_dir;
   dir_t        head;

   assign tick     = vs_d && !vs_s2;
   assign rollover = (keycode[7:0] == KC_ROLLOVER) || (keycode[15:8] == KC_ROLLOVER);

   // Bring the asynchronous VS into the Clk domain and keep one stage for edge detect.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_s1 <= 1'b1;
         vs_s2 <= 1'b1;
         vs_d  <= 1'b1;
      end else begin
         vs_s1 <= frame_vs;
         vs_s2 <= vs_s1;
         vs_d  <= vs_s2;
      end
   end

   // Capture the keycode on a tick; a rollover sample never reaches decode.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         cur_sample  <= '0;
         prev_sample <= '0;
         decode_en   <= 1'b0;
      end else begin
         decode_en <= tick && !rollover;
         if (tick) cur_sample <= keycode;
         if (decode_en) prev_sample <= cur_sample;
      end
   end

   // New-press decode with slot0 priority; at most one move per frame.
   always_comb begin
      m0 = map_key(cur_sample[7:0]);
      m1 = map_key(cur_sample[15:8]);
      new0 = (cur_sample[7:0] != 8'h00) && (cur_sample[7:0] != prev_sample[7:0])
             && (cur_sample[7:0] != prev_sample[15:8]);
      new1 = (cur_sample[15:8] != 8'h00) && (cur_sample[15:8] != prev_sample[7:0])
             && (cur_sample[15:8] != prev_sample[15:8]);
      press_hit = 1'b0;
      press_dir = DIR_UP;
      if (new0 && m0.hit) begin
         press_hit = 1'b1;
         press_dir = m0.dir;
      end else if (new1 && m1.hit) begin
         press_hit = 1'b1;
         press_dir = m1.dir;
      end
      pause_toggle = decode_en && ((new0 && cur_sample[7:0] == KC_SPACE) ||
                                   (new1 && cur_sample[15:8] == KC_SPACE));
      push     = decode_en && (press_hit || rep_fire);
      push_dir = press_hit ? press_dir : rep_dir_out;
   end

`ifdef FROGGER_AUTOREPEAT_EN
   localparam int RCW = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);

   key_map_t       pm0, pm1;
   logic           held_hit;
   dir_t           held_dir;
   dir_t           rep_dir;
   logic [RCW-1:0] rep_cnt, rep_nxt;

   // Find the held direction and the frame count it would reach this tick.
   always_comb begin
      pm0      = map_key(prev_sample[7:0]);
      pm1      = map_key(prev_sample[15:8]);
      held_hit = 1'b0;
      held_dir = DIR_UP;
      if (m0.hit && ((pm0.hit && pm0.dir == m0.dir) || (pm1.hit && pm1.dir == m0.dir))) begin
         held_hit = 1'b1;
         held_dir = m0.dir;
      end else if (m1.hit && ((pm0.hit && pm0.dir == m1.dir) || (pm1.hit && pm1.dir == m1.dir))) begin
         held_hit = 1'b1;
         held_dir = m1.dir;
      end
      rep_nxt = '0;
      if (held_hit) rep_nxt = (rep_cnt != '0 && held_dir == rep_dir) ? rep_cnt + 1'b1 : RCW'(1);
      rep_fire    = held_hit && (rep_nxt == RCW'(REPEAT_DELAY) ||
                                 rep_nxt == RCW'(REPEAT_DELAY + REPEAT_RATE));
      rep_dir_out = held_dir;
   end

   // Count held frames; after the first repeat the count folds back every REPEAT_RATE.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rep_cnt <= '0;
         rep_dir <= DIR_UP;
      end else if (decode_en) begin
         rep_cnt <= (rep_nxt == RCW'(REPEAT_DELAY + REPEAT_RATE)) ? RCW'(REPEAT_DELAY) : rep_nxt;
         if (held_hit) rep_dir <= held_dir;
      end
   end
`else
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;
   assign rep_fire    = 1'b0;
   assign rep_dir_out = DIR_UP;
`endif

   move_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (Clk),
      .reset    (Reset),
      .push     (push),
      .push_dir (push_dir),
      .pop      (move_ready),
      .valid    (move_valid),
      .head     (head),
      .count    (fifo_count),
      .overflow (overflow)
   );

   assign move_dir = head;

endmodule

// File: tb/tb_frog_move_decoder.sv
// Directed bench for frog_move_decoder (DEPTH=4). Autorepeat scenario is built
// only when FROGGER_AUTOREPEAT_EN is defined.
module tb_frog_move_decoder;

   logic        clk;
   logic        Reset;
   logic [15:0] keycode;
   logic        frame_vs;
   logic        move_valid;
   logic [1:0]  move_dir;
   logic        move_ready;
   logic        pause_toggle;
   logic [2:0]  fifo_count;
   logic        overflow;

   int n_vec;
   int n_err;

   logic obs_valid_t1, obs_valid_t2, obs_pause_t1;
   int   obs_pause_total;

   frog_move_decoder #(.DEPTH(4)) dut (
      .Clk          (clk),
      .Reset        (Reset),
      .keycode      (keycode),
      .frame_vs     (frame_vs),
      .move_valid   (move_valid),
      .move_dir     (move_dir),
      .move_ready   (move_ready),
      .pause_toggle (pause_toggle),
      .fifo_count   (fifo_count),
      .overflow     (overflow)
   );

   // clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // One VS low pulse. Entered #1 after a posedge; T is the cycle after the 2nd edge.
   task automatic frame(input logic [15:0] key, input logic pop_t1);
      keycode = key;
      frame_vs = 1'b0;
      obs_pause_total = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (pause_toggle) obs_pause_total++;
         if (i == 2) begin
            obs_valid_t1 = move_valid;
            obs_pause_t1 = pause_toggle;
            if (pop_t1) move_ready = 1'b1;
         end
         if (i == 3) begin
            obs_valid_t2 = move_valid;
            move_ready = 1'b0;
         end
      end
      frame_vs = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         if (pause_toggle) obs_pause_total++;
      end
   endtask

   task automatic pop_one();
      move_ready = 1'b1;
      @(posedge clk); #1;
      move_ready = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_vec++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", move_valid); end
      n_vec++; if (move_dir !== 2'd0) begin n_err++; $display("FAIL reset_dir got %0d exp 0", move_dir); end
      n_vec++; if (pause_toggle !== 1'b0) begin n_err++; $display("FAIL reset_pause got %b exp 0", pause_toggle); end
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b exp 0", overflow); end
      Reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_latency();
      frame(16'h001A, 1'b0);
      n_vec++; if (obs_valid_t1 !== 1'b0) begin n_err++; $display("FAIL lat_valid_t1 got %b exp 0", obs_valid_t1); end
      n_vec++; if (obs_valid_t2 !== 1'b1) begin n_err++; $display("FAIL lat_valid_t2 got %b exp 1", obs_valid_t2); end
      n_vec++; if (move_dir !== 2'd0) begin n_err++; $display("FAIL lat_dir got %0d exp 0", move_dir); end
      for (int f = 0; f < 3; f++) frame(16'h001A, 1'b0);
      n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL held_count got %0d exp 1", fifo_count); end
      pop_one();
      n_vec++; if (move_valid !== 1'b0) begin n_err++; $display("FAIL lat_pop_valid got %b exp 0", move_valid); end
   endtask

   task automatic test_slot_priority();
      frame(16'h0750, 1'b0);
      n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL prio_count got %0d exp 1", fifo_count); end
      n_vec++; if (move_dir !== 2'd2) begin n_err++; $display("FAIL prio_dir got %0d exp 2", move_dir); end
      frame(16'h0700, 1'b0);
      n_vec++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL prio_release_count got %0d exp 1", fifo_count); end
      pop_one();
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL prio_pop_count got %0d exp 0", fifo_count); end
   endtask

   task automatic test_overflow();
      logic [1:0] exp_q[$];
      frame(16'h001A, 1'b0);
      frame(16'h0016, 1'b0);
      frame(16'h0004, 1'b0);
      frame(16'h0007, 1'b0);
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before got %b exp 0", overflow); end
      frame(16'h0052, 1'b0);
      n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d exp 4", fifo_count); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
      n_vec++; if (move_dir !== 2'd0) begin n_err++; $display("FAIL ovf_head got %0d exp 0", move_dir); end
      frame(16'h0051, 1'b1);
      n_vec++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count got %0d exp 4", fifo_count); end
      n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL full_pushpop_ovf got %b exp 1", overflow); end
      exp_q = '{2'd1, 2'd2, 2'd3, 2'd1};
      while (exp_q.size() > 0) begin
         n_vec++; if (move_valid !== 1'b1 || move_dir !== exp_q[0]) begin
            n_err++; $display("FAIL drain_head got v=%b d=%0d exp v=1 d=%0d", move_valid, move_dir, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop_one();
      end
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL drain_count got %0d exp 0", fifo_count); end
      pop_one();
      n_vec++; if (fifo_count !== 3'd0 || move_valid !== 1'b0) begin
         n_err++; $display("FAIL empty_pop got c=%0d v=%b exp c=0 v=0", fifo_count, move_valid);
      end
   endtask

   task automatic test_pause_rollover();
      frame(16'h0101, 1'b0);
      n_vec++; if (obs_pause_total != 0) begin n_err++; $display("FAIL rollover_pause got %0d exp 0", obs_pause_total); end
      frame(16'h002C, 1'b0);
      n_vec++; if (obs_pause_t1 !== 1'b1) begin n_err++; $display("FAIL pause_t1 got %b exp 1", obs_pause_t1); end
      n_vec++; if (obs_pause_total != 1) begin n_err++; $display("FAIL pause_width got %0d exp 1", obs_pause_total); end
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL pause_nopush got %0d exp 0", fifo_count); end
      frame(16'h0101, 1'b0);
      frame(16'h002C, 1'b0);
      n_vec++; if (obs_pause_total != 0) begin n_err++; $display("FAIL pause_held got %0d exp 0", obs_pause_total); end
      frame(16'h0104, 1'b0);
      n_vec++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL rollover_move got %0d exp 0", fifo_count); end
   endtask

   task automatic test_reset_mid();
      frame(16'h0004, 1'b0);
      frame(16'h0007, 1'b0);
      frame(16'h0052, 1'b0);
      n_vec++; if (fifo_count !== 3'd3) begin n_err++; $display("FAIL mid_fill got %0d exp 3", fifo_count); end
      Reset = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (fifo_count !== 3'd0 || move_valid !== 1'b0) begin
         n_err++; $display("FAIL mid_reset got c=%0d v=%b exp c=0 v=0", fifo_count, move_valid);
      end
      n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL mid_reset_ovf got %b exp 0", overflow); end
      Reset = 1'b0;
      @(posedge clk); #1;
      frame(16'h0052, 1'b0);
      n_vec++; if (fifo_count !== 3'd1 || move_dir !== 2'd0) begin
         n_err++; $display("FAIL held_over_reset got c=%0d d=%0d exp c=1 d=0", fifo_count, move_dir);
      end
      pop_one();
   endtask

`ifdef FROGGER_AUTOREPEAT_EN
   task automatic test_autorepeat();
      int exp_q[$];
      logic exp_push;
      exp_q = '{0, 20, 26, 32, 38};
      for (int f = 0; f < 40; f++) begin
         frame(16'h0004, 1'b0);
         exp_push = (exp_q.size() > 0) && (exp_q[0] == f);
         n_vec++; if (move_valid !== exp_push || (exp_push && move_dir !== 2'd2)) begin
            n_err++; $display("FAIL repeat_frame%0d got v=%b d=%0d exp v=%b d=2", f, move_valid, move_dir, exp_push);
         end
         if (exp_push) void'(exp_q.pop_front());
         if (move_valid) pop_one();
      end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      Reset = 1'b1;
      keycode = 16'h0000;
      frame_vs = 1'b1;
      move_ready = 1'b0;
      test_reset();
      test_latency();
      test_slot_priority();
      test_overflow();
      test_pause_rollover();
      test_reset_mid();
`ifdef FROGGER_AUTOREPEAT_EN
      test_autorepeat();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
